// File: rtl/ob_drain_pkg.sv
// Shared types for the output-buffer drain engine.
package ob_drain_pkg;

  localparam int OB_WIDTH = 8;
  localparam int OB_COL   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } drain_state_e;

  // One output-buffer word at the default geometry.
  typedef logic [OB_COL-1:0][OB_WIDTH-1:0] ob_word_t;

endpackage

// File: rtl/ob_drain_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs the SRAM read latency under backpressure.
module ob_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [1:0]        count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr;
  logic              r_rd;
  logic [1:0]        r_cnt;
  logic              w_push;
  logic              w_pop;

  assign empty_o = (r_cnt == 2'd0);
  assign full_o  = (r_cnt == 2'd2);
  assign count_o = r_cnt;
  assign w_pop   = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_push  = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end

  // Storage is not reset, so the head reads as zero whenever nothing is held.
  assign head_o = empty_o ? '0 : r_mem[r_rd];

endmodule

// File: rtl/ob_drain.sv
// Drains a run of output-buffer SRAM words onto a valid/ready stream.
module ob_drain
  import ob_drain_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int COL    = 4,
  parameter int O_SIZE = 256
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  input  logic [$clog2(O_SIZE)-1:0]   base_addr_i,
  input  logic [$clog2(O_SIZE):0]     count_i,
  output logic                        ob_mem_cenb_o,
  output logic                        ob_mem_wenb_o,
  output logic [$clog2(O_SIZE)-1:0]   ob_mem_addr_o,
  input  logic [COL-1:0][WIDTH-1:0]   ob_mem_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [COL-1:0][WIDTH-1:0]   out_data_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int AW = $clog2(O_SIZE);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int DW = COL * WIDTH;
  localparam logic [CW-1:0] MAXCNT = CW'(O_SIZE);

  drain_state_e  r_state;
  logic [AW-1:0] r_base;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_issued;
  logic [CW-1:0] r_popped;
  logic          r_inflight;
  logic          r_busy;
  logic          r_done;

  logic          w_issue;
  logic          w_pop;
  logic          w_last;
  logic          w_empty;
  logic          w_full;
  logic [1:0]    w_fifo_cnt;
  logic [DW-1:0] w_head;
  logic [2:0]    w_occ;
  logic [SW-1:0] w_sum;
  logic [AW-1:0] w_wrapped;
  logic [AW-1:0] w_addr;
  logic [CW-1:0] w_count_in;

  assign w_pop = ~w_empty & out_ready_i;
  assign w_occ = {1'b0, w_fifo_cnt} + {2'b00, r_inflight};

  // Credit: FIFO entries plus the read in flight, less this cycle's pop, must leave a slot.
  assign w_issue = (r_state == RUN) && (r_issued < r_count) &&
                   (w_occ < (3'd2 + {2'b00, w_pop})) && (~w_full | w_pop);

  assign w_sum     = {2'b00, r_base} + {1'b0, r_issued};
  assign w_wrapped = AW'(w_sum - SW'(O_SIZE));
  assign w_addr    = (w_sum >= SW'(O_SIZE)) ? w_wrapped : AW'(w_sum);

  assign w_last     = ~w_empty && (r_popped == (r_count - CW'(1)));
  assign w_count_in = (count_i > MAXCNT) ? MAXCNT : count_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b1;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_issued <= r_issued + CW'(1);
      if (w_pop)   r_popped <= r_popped + CW'(1);
      case (r_state)
        IDLE: begin
          if (start_i && (count_i != '0)) begin
            r_state  <= RUN;
            r_base   <= base_addr_i;
            r_count  <= w_count_in;
            r_issued <= '0;
            r_popped <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        RUN: begin
          if (w_pop && w_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after issue and is pushed only if that read is still owned.
  ob_skid_fifo #(
    .DATA_W (DW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (r_inflight),
    .pop_i   (w_pop),
    .data_i  (ob_mem_data_i),
    .head_o  (w_head),
    .count_o (w_fifo_cnt),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  assign ob_mem_cenb_o = ~w_issue;
  assign ob_mem_wenb_o = 1'b1;
  assign ob_mem_addr_o = w_issue ? w_addr : '0;
  assign out_valid_o   = ~w_empty;
  assign out_data_o    = w_head;
  assign out_last_o    = w_last;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule

// File: tb/tb_ob_drain.sv
// Randomized bench for ob_drain with a queue-based reference model of each run.
module tb_ob_drain;

  localparam int WIDTH  = 8;
  localparam int COL    = 4;
  localparam int O_SIZE = 256;
  localparam int AW     = 8;
  localparam int CW     = 9;
  localparam int DW     = 32;

  logic                      clk = 1'b0;
  logic                      rstn;
  logic                      start;
  logic [AW-1:0]             base;
  logic [CW-1:0]             cnt;
  logic                      cenb;
  logic                      wenb;
  logic [AW-1:0]             addr;
  logic [COL-1:0][WIDTH-1:0] rdata;
  logic [COL-1:0][WIDTH-1:0] odata;
  logic                      ovalid;
  logic                      oready;
  logic                      olast;
  logic                      busy;
  logic                      done;

  always #5 clk = ~clk;

  ob_drain #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .start_i       (start),
    .base_addr_i   (base),
    .count_i       (cnt),
    .ob_mem_cenb_o (cenb),
    .ob_mem_wenb_o (wenb),
    .ob_mem_addr_o (addr),
    .ob_mem_data_i (rdata),
    .out_valid_o   (ovalid),
    .out_ready_i   (oready),
    .out_data_o    (odata),
    .out_last_o    (olast),
    .busy_o        (busy),
    .done_o        (done)
  );

  logic [DW-1:0] mem [O_SIZE];
  always @(posedge clk) if (!cenb) rdata <= mem[addr];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            m_busy     = 0;
  int            just_reset = 0;
  int            rel        = 0;
  int            rd_total   = 0;
  int            pop_total  = 0;
  int            m_n        = 0;
  logic          prev_valid = 1'b0;
  logic          prev_pop   = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  int            st_first_rd, st_first_vld, st_last_pop, st_done, st_nlast, st_nrd;
  logic [AW-1:0] addr_log [512];

  always @(negedge clk) begin
    if (!rstn) begin
      m_busy = 0;
      exp_q.delete();
      addr_q.delete();
      just_reset = 1;
      prev_valid = 1'b0;
      prev_pop = 1'b0;
      rd_total = 0;
      pop_total = 0;
    end else begin
      if (just_reset != 0) begin
        chk("rst_cenb", cenb, 1);
        chk("rst_wenb", wenb, 1);
        chk("rst_addr", addr, 0);
        chk("rst_valid", ovalid, 0);
        chk("rst_data", odata, 0);
        chk("rst_last", olast, 0);
        just_reset = 0;
      end
      rel++;
      chk("busy", busy, (m_busy != 0));
      chk("done", done, (m_busy == 0));
      chk("wenb", wenb, 1);
      if (!cenb) begin
        if (addr_q.size() == 0) chk("rd_extra", addr, 64'hFFFF_FFFF);
        else chk("rd_addr", addr, addr_q.pop_front());
        addr_log[st_nrd % 512] = addr;
        if (st_first_rd < 0) st_first_rd = rel;
        st_nrd++;
        rd_total++;
      end
      if (ovalid) begin
        if (exp_q.size() == 0) chk("vld_extra", odata, 64'hFFFF_FFFF_FFFF);
        else begin
          chk("data", odata, exp_q[0]);
          chk("last", olast, (exp_q.size() == 1));
        end
        if (prev_valid && !prev_pop) chk("hold", odata, prev_data);
        if (st_first_vld < 0) st_first_vld = rel;
        if (oready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          pop_total++;
          if (olast) st_nlast++;
        end
      end else begin
        chk("last_novld", olast, 0);
        if (prev_valid && !prev_pop) chk("vld_drop", ovalid, 1);
      end
      chk("outstanding", ((rd_total - pop_total) <= 2), 1);
      if (m_busy == 0 && done && st_done < 0 && st_last_pop >= 0) st_done = rel;
      prev_valid = ovalid;
      prev_pop   = ovalid & oready;
      prev_data  = odata;
      // Next-cycle model state from this cycle's inputs.
      if (m_busy != 0) begin
        if (ovalid && oready && olast) begin
          m_busy = 0;
          st_last_pop = rel;
        end
      end else if (start && cnt != 0) begin
        m_busy = 1;
        m_n = (int'(cnt) > O_SIZE) ? O_SIZE : int'(cnt);
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < m_n; i++) begin
          exp_q.push_back(mem[(int'(base) + i) % O_SIZE]);
          addr_q.push_back(AW'((int'(base) + i) % O_SIZE));
        end
        rel = 0;
        rd_total = 0;
        pop_total = 0;
        st_first_rd = -1; st_first_vld = -1; st_last_pop = -1;
        st_done = -1; st_nlast = 0; st_nrd = 0;
      end
    end
  end

  // Ready pattern: 0 always, 1 one-in-three, 2 random, 3 never.
  int rmode  = 0;
  int rphase = 0;
  initial begin
    oready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rphase++;
      case (rmode)
        0:       oready = 1'b1;
        1:       oready = ((rphase % 3) == 0);
        2:       oready = 1'($urandom_range(0, 1));
        default: oready = 1'b0;
      endcase
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < O_SIZE; i++) mem[i] = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] c);
    @(posedge clk); #1;
    start = 1'b1; base = b; cnt = c;
    @(posedge clk); #1;
    start = 1'b0; base = AW'($urandom); cnt = CW'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (m_busy != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("timeout", m_busy, 0);
    if (m_busy != 0) do_reset();
    repeat (2) @(posedge clk);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [AW-1:0] b;
    logic [CW-1:0] c;
    rstn = 1'b0; start = 1'b0; base = '0; cnt = '0;
    st_first_rd = -1; st_first_vld = -1; st_last_pop = -1;
    st_done = -1; st_nlast = 0; st_nrd = 0;
    fill_mem();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-length start is ignored.
    do_start(8'h33, 9'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("cnt0_done", done, 1);
    chk("cnt0_busy", busy, 0);

    // Base 0x10, four words, consumer always ready.
    rmode = 0;
    fill_mem();
    do_start(8'h10, 9'd4);
    wait_done(50);
    chk("t2_first_rd", st_first_rd, 1);
    chk("t2_first_vld", st_first_vld, 3);
    chk("t2_last_pop", st_last_pop, 6);
    chk("t2_done", st_done, 7);
    chk("t2_nlast", st_nlast, 1);
    chk("t2_nrd", st_nrd, 4);
    chk("t2_addr0", addr_log[0], 8'h10);
    chk("t2_addr3", addr_log[3], 8'h13);

    // Address wrap.
    do_start(8'hFE, 9'd4);
    wait_done(50);
    chk("wrap_a0", addr_log[0], 8'hFE);
    chk("wrap_a1", addr_log[1], 8'hFF);
    chk("wrap_a2", addr_log[2], 8'h00);
    chk("wrap_a3", addr_log[3], 8'h01);

    // Stalling consumer.
    rmode = 1;
    fill_mem();
    do_start(8'h77, 9'd8);
    wait_done(200);
    chk("stall_nlast", st_nlast, 1);
    chk("stall_nrd", st_nrd, 8);

    // Full-depth run with a start pulse while busy.
    rmode = 0;
    fill_mem();
    do_start(8'h5A, 9'd256);
    repeat (20) @(posedge clk);
    #1 start = 1'b1; base = 8'h00; cnt = 9'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(600);
    chk("full_nrd", st_nrd, 256);
    chk("full_nlast", st_nlast, 1);
    chk("full_last_pop", st_last_pop, 258);

    // Oversized count clamps to the buffer depth.
    rmode = 2;
    fill_mem();
    do_start(8'hC3, 9'd511);
    wait_done(2000);
    chk("clamp_nrd", st_nrd, 256);
    chk("clamp_nlast", st_nlast, 1);

    // Reset mid-run with the FIFO full, then a fresh run.
    rmode = 3;
    do_start(8'h80, 9'd8);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_valid", ovalid, 1);
    do_reset();
    rmode = 0;
    fill_mem();
    do_start(8'h40, 9'd5);
    wait_done(50);
    chk("post_rst_last_pop", st_last_pop, 7);
    chk("post_rst_nrd", st_nrd, 5);
    chk("post_rst_a0", addr_log[0], 8'h40);

    // Random runs.
    rmode = 2;
    for (int r = 0; r < 8; r++) begin
      b = AW'($urandom);
      c = CW'($urandom_range(1, 20));
      fill_mem();
      do_start(b, c);
      wait_done(300);
      chk("rand_nlast", st_nlast, 1);
      chk("rand_nrd", st_nrd, c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
